// File: rtl/pipe_mem_arbiter.sv
// pipe_mem_arbiter: shares one memory port between IF fetch and MEM load/store, DM first.
// Define MEM_ARB_STATS_EN to build saturating stall-cycle counters on stat_*_wait_o.
module pipe_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ready_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ready_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              stall_if_o,
  output logic              stall_mem_o,
  output logic [31:0]       stat_if_wait_o,
  output logic [31:0]       stat_dm_wait_o
);

  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_DM} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_if_ready;
  logic              r_dm_ready;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              w_if_elig;
  logic              w_dm_elig;
  logic              w_grant_if;
  logic              w_grant_dm;
  logic              w_done_if;
  logic              w_done_dm;
  logic              w_mem_req;

  // A requester whose ready pulse is showing this cycle is not eligible again yet.
  assign w_if_elig = if_req_i & ~r_if_ready;
  assign w_dm_elig = dm_req_i & ~r_dm_ready;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_dm_elig)      w_next = GNT_DM;
        else if (w_if_elig) w_next = GNT_IF;
      end
      GNT_IF, GNT_DM: if (mem_ack_i) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_mem_req  = (r_state == GNT_IF) || (r_state == GNT_DM);
    w_grant_dm = (r_state == IDLE) && w_dm_elig;
    w_grant_if = (r_state == IDLE) && !w_dm_elig && w_if_elig;
    w_done_if  = (r_state == GNT_IF) && mem_ack_i;
    w_done_dm  = (r_state == GNT_DM) && mem_ack_i;
  end

  // Fetches drive zero write data so the bus never carries stale store data.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_grant_dm) begin
      r_mem_we    <= dm_we_i;
      r_mem_addr  <= dm_addr_i;
      r_mem_wdata <= dm_wdata_i;
    end else if (w_grant_if) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= if_addr_i;
      r_mem_wdata <= '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_if_ready <= 1'b0;
      r_dm_ready <= 1'b0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      r_if_ready <= w_done_if;
      r_dm_ready <= w_done_dm;
      if (w_done_if)              r_if_rdata <= mem_rdata_i;
      if (w_done_dm && !r_mem_we) r_dm_rdata <= mem_rdata_i;
    end
  end

  assign if_ready_o  = r_if_ready;
  assign dm_ready_o  = r_dm_ready;
  assign if_rdata_o  = r_if_rdata;
  assign dm_rdata_o  = r_dm_rdata;
  assign mem_req_o   = w_mem_req;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign stall_if_o  = if_req_i & ~r_if_ready;
  assign stall_mem_o = dm_req_i & ~r_dm_ready;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] r_stat_if_wait;
  logic [31:0] r_stat_dm_wait;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stat_if_wait <= '0;
      r_stat_dm_wait <= '0;
    end else begin
      if (stall_if_o && (r_stat_if_wait != 32'hFFFF_FFFF))
        r_stat_if_wait <= r_stat_if_wait + 32'd1;
      if (stall_mem_o && (r_stat_dm_wait != 32'hFFFF_FFFF))
        r_stat_dm_wait <= r_stat_dm_wait + 32'd1;
    end
  end

  assign stat_if_wait_o = r_stat_if_wait;
  assign stat_dm_wait_o = r_stat_dm_wait;
`else
  assign stat_if_wait_o = 32'd0;
  assign stat_dm_wait_o = 32'd0;
`endif

endmodule

// File: doc/pipe_mem_arbiter.md
# pipe_mem_arbiter

Single-port memory arbiter and sequencer for the pipelined CPU. It shares one unified instruction/data memory port between the IF-stage fetch requester and the MEM-stage load/store requester. Accesses run through a request/acknowledge handshake of variable latency, and the block raises stall signals that the hazard logic uses to freeze the PC and the pipeline registers. It sits between the PC/IF_ID logic, the EX_MEM/MEM_WB logic, and the memory model.

## Interface
Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports

Ports:
- clk_i  in  1  single clock; all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- if_req_i  in  1  fetch request, level; held until if_ready_o seen
- if_addr_i  in  ADDR_W  fetch address (PC)
- if_rdata_o  out  DATA_W  fetched instruction, registered
- if_ready_o  out  1  one-cycle completion pulse for fetch
- dm_req_i  in  1  load/store request, level; held until dm_ready_o seen
- dm_we_i  in  1  1 = store, 0 = load
- dm_addr_i  in  ADDR_W  data address (ALU result)
- dm_wdata_i  in  DATA_W  store data
- dm_rdata_o  out  DATA_W  load data, registered
- dm_ready_o  out  1  one-cycle completion pulse for load/store
- mem_req_o  out  1  memory request, held until mem_ack_i
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address, stable while mem_req_o=1
- mem_wdata_o  out  DATA_W  memory write data, stable while mem_req_o=1
- mem_rdata_i  in  DATA_W  memory read data, valid with mem_ack_i
- mem_ack_i  in  1  memory completion; may be tied high
- stall_if_o  out  1  if_req_i & ~if_ready_o, combinational
- stall_mem_o  out  1  dm_req_i & ~dm_ready_o, combinational
- stat_if_wait_o  out  32  fetch stall-cycle count
- stat_dm_wait_o  out  32  data stall-cycle count

## Operation
- FSM states: IDLE, GNT_IF, GNT_DM.
- In IDLE, a requester is eligible when its req_i=1 and its ready_o=0 in that cycle. The ready_o mask stops a just-served requester from being re-granted.
- In IDLE, a DM request has priority: an eligible DM request moves the FSM to GNT_DM. Otherwise an eligible IF request moves it to GNT_IF.
- On entry to a grant state, the FSM latches addr, we (IF forces we=0) and wdata into output registers.
- In a grant state, mem_req_o=1 and the FSM holds there while mem_ack_i=0.
- On mem_ack_i=1 in a grant state, the FSM returns to IDLE and pulses the grantee's ready_o in the next cycle.
  - For a read, rdata_o captures mem_rdata_i at the ack edge.
  - For a store, dm_rdata_o is unchanged.
- rdata_o holds its value until that port's next read completes.
- mem_ack_i outside a grant state is ignored.
- Requesters must keep addr/we/wdata stable while req_i=1. Dropping req_i mid-grant does not abort the access; the access completes and ready_o still pulses.

## Timing
- Reset (async assert): state=IDLE. All outputs 0: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, if/dm_ready_o, if/dm_rdata_o, stat counters. mem_req_o drops immediately, mid-access included, and the in-flight access is discarded.
- Zero-wait memory (ack tied high):
  - request seen at cycle N
  - mem_req_o=1 at N+1
  - ready_o=1 at N+2
  - the same requester's next request is granted no earlier than N+3 (IDLE at N+3 → GNT at N+4)
- Each cycle of ack delay adds one cycle.
- Simultaneous requests at cycle N (zero-wait): DM is granted at N+1 with dm_ready at N+2. IF is granted at N+3 with if_ready at N+4. stall_if_o stays high N..N+3.
- One access in flight at most; no pipelining of memory requests.

## Configuration
- MEM_ARB_STATS_EN defined:
  - stat_if_wait_o increments on each cycle with stall_if_o=1.
  - stat_dm_wait_o increments on each cycle with stall_mem_o=1.
  - Both counters are 32-bit, saturate at 32'hFFFFFFFF, and are cleared only by reset.
- MEM_ARB_STATS_EN undefined: both stat outputs are constant 0 and no counter flops are built.

## Test plan
- Reset mid-access: rst_i low during GNT_DM with ack held low → mem_req_o=0 asynchronously, state IDLE, all outputs 0 after release.
- Single fetch, ack tied high, if_addr_i=0x10, mem_rdata_i=0x8C020004 → mem_req_o=1, mem_we_o=0, mem_addr_o=0x10 one cycle after request; if_ready_o pulse and if_rdata_o=0x8C020004 two cycles after request.
- Store at 0x20 of 0xDEADBEEF with 3-cycle ack delay → mem_we_o=1 and address/data stable for 3 cycles, dm_ready_o a single-cycle pulse, dm_rdata_o unchanged.
- Simultaneous IF and DM requests at cycle N → DM served first (dm_ready at N+2), IF served next (if_ready at N+4), no double grant of DM.
- Held requests: if_req_i held high across ready → requester re-granted only after the ready cycle, exactly one mem_req_o assertion per access.
- With MEM_ARB_STATS_EN, 10 fetch stall cycles → stat_if_wait_o=10. Forcing the counter to 0xFFFFFFFF and stalling again → value stays saturated. Without the macro → both stat outputs read 0.
